register_file: RTL and testbench

//   Multi-ported register file: one synchronous write port, three asynchronous read ports.

---
 rtl/register_file_if.sv | 28 ++
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file bus: one write port and three combinational read ports.
// The datapath side (master) drives addresses/data; the register file (slave) returns read data.
interface register_file_if #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_AMOUNT  = 8
);
  localparam int AW = (REG_AMOUNT > 1) ? $clog2(REG_AMOUNT) : 1;

  logic                   wrEn;
  logic [AW-1:0]          addrWrite;
  logic [WORD_LENGTH-1:0] dataIn;
  logic [AW-1:0]          addrRead1;
  logic [AW-1:0]          addrRead2;
  logic [AW-1:0]          addrRead3;
  logic [WORD_LENGTH-1:0] dataOut1;
  logic [WORD_LENGTH-1:0] dataOut2;
  logic [WORD_LENGTH-1:0] dataOut3;

  modport master (
    output wrEn, addrWrite, dataIn, addrRead1, addrRead2, addrRead3,
    input  dataOut1, dataOut2, dataOut3
  );

  modport slave (
    input  wrEn, addrWrite, dataIn, addrRead1, addrRead2, addrRead3,
    output dataOut1, dataOut2, dataOut3
  );
endinterface

// File: rtl/register_file.sv
// General-purpose register bank: synchronous single write port, three asynchronous read ports.
// Out-of-range addresses (non-power-of-two REG_AMOUNT) match no register: writes drop, reads give 0.
module rf_read_port #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_AMOUNT  = 8,
  parameter int AW          = 3
) (
  input  logic [REG_AMOUNT-1:0][WORD_LENGTH-1:0] regs,
  input  logic [AW-1:0]                          addr,
  output logic [WORD_LENGTH-1:0]                 data
);
  always_comb begin
    data = '0;
    for (int r = 0; r < REG_AMOUNT; r++)
      if (addr == AW'(r)) data = regs[r];
  end
endmodule

module register_file #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_AMOUNT  = 8
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);
  localparam int AW     = (REG_AMOUNT > 1) ? $clog2(REG_AMOUNT) : 1;
  localparam int NUM_RD = 3;

  logic [REG_AMOUNT-1:0][WORD_LENGTH-1:0] regs;
  logic [NUM_RD-1:0][AW-1:0]              rd_addr;
  logic [NUM_RD-1:0][WORD_LENGTH-1:0]     rd_data;

  // Reset wins over a coincident write; decode by equality so stray addresses hit nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < REG_AMOUNT; r++)
        if (bus.wrEn && bus.addrWrite == AW'(r)) regs[r] <= bus.dataIn;
    end
  end

  assign rd_addr = {bus.addrRead3, bus.addrRead2, bus.addrRead1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .WORD_LENGTH(WORD_LENGTH),
      .REG_AMOUNT (REG_AMOUNT),
      .AW         (AW)
    ) u_rd (
      .regs(regs),
      .addr(rd_addr[p]),
      .data(rd_data[p])
    );
  end

  // No write-to-read bypass: reads see stored contents only.
  assign bus.dataOut1 = rd_data[0];
  assign bus.dataOut2 = rd_data[1];
  assign bus.dataOut3 = rd_data[2];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, hand sequences and a random run
// against a reference array, with expected reads queued at drive time and popped after the edge.
module tb_register_file;
  localparam int WL = 8;
  localparam int RA = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  register_file_if #(.WORD_LENGTH(WL), .REG_AMOUNT(RA)) bus ();

  register_file #(.WORD_LENGTH(WL), .REG_AMOUNT(RA)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] din;
    logic [2:0] ra1, ra2, ra3;
    logic [7:0] e1, e2, e3;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] e1, e2, e3;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [RA];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [2:0] wa, input logic [7:0] din,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3);
    bus.wrEn = wr; bus.addrWrite = wa; bus.dataIn = din;
    bus.addrRead1 = r1; bus.addrRead2 = r2; bus.addrRead3 = r3;
  endtask

  // One edge: expectation already queued by the caller, popped and compared after the edge.
  task automatic edge_and_pop();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.name, ".d1"}, bus.dataOut1, e.e1);
      check({e.name, ".d2"}, bus.dataOut2, e.e2);
      check({e.name, ".d3"}, bus.dataOut3, e.e3);
    end
  endtask

  task automatic model_cycle(input string name, input logic wr, input logic [2:0] wa,
                             input logic [7:0] din, input logic [2:0] r1,
                             input logic [2:0] r2, input logic [2:0] r3);
    exp_t e;
    drive(wr, wa, din, r1, r2, r3);
    if (wr) model[wa] = din;
    e.name = name; e.e1 = model[r1]; e.e2 = model[r2]; e.e3 = model[r3];
    sb.push_back(e);
    edge_and_pop();
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd0, 3'd0, 8'h3C, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 3'd2, 8'hFF, 3'd2, 3'd5, 3'd2, 8'h00, 8'h3C, 8'h00};
    vecs[2] = '{1'b1, 3'd1, 8'h11, 3'd1, 3'd5, 3'd0, 8'h11, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 3'd6, 8'h66, 3'd6, 3'd1, 3'd5, 8'h66, 8'h11, 8'h3C};
    vecs[4] = '{1'b1, 3'd7, 8'h77, 3'd1, 3'd6, 3'd7, 8'h11, 8'h66, 8'h77};
    vecs[5] = '{1'b0, 3'd7, 8'h00, 3'd7, 3'd7, 3'd7, 8'h77, 8'h77, 8'h77};
    vecs[6] = '{1'b1, 3'd0, 8'h5A, 3'd0, 3'd7, 3'd2, 8'h5A, 8'h77, 8'h00};
    vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0, 8'h5A, 8'h5A, 8'h5A};

    // Reset state: write lands on reg 3 during reset and must be dropped.
    rst = 1'b1;
    drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 3'd3);
    @(posedge clk); #1;
    check("rst_prio.d1", bus.dataOut1, 8'h00);
    rst = 1'b0;
    for (int r = 0; r < RA; r++) model[r] = 8'h00;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0);
    for (int r = 0; r < RA; r += 3) begin
      bus.addrRead1 = 3'(r); bus.addrRead2 = 3'(r + 1); bus.addrRead3 = 3'(r + 2);
      #1;
      check($sformatf("rst_state.r%0d", r),     bus.dataOut1, 8'h00);
      check($sformatf("rst_state.r%0d", r + 1), bus.dataOut2, 8'h00);
      check($sformatf("rst_state.r%0d", r + 2), bus.dataOut3, 8'h00);
    end

    // Reset sequence: A5 into reg 3, then 3 reset edges.
    model_cycle("wr_a5", 1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 3'd3);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int r = 0; r < RA; r++) model[r] = 8'h00;
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 3'd3);
    #1;
    check("rst3.d1", bus.dataOut1, 8'h00);
    check("rst3.d2", bus.dataOut2, 8'h00);
    check("rst3.d3", bus.dataOut3, 8'h00);

    // Table vectors; expected values are the reads after each vector's edge.
    foreach (vecs[i]) begin
      exp_t e;
      drive(vecs[i].wr, vecs[i].wa, vecs[i].din, vecs[i].ra1, vecs[i].ra2, vecs[i].ra3);
      if (vecs[i].wr) model[vecs[i].wa] = vecs[i].din;
      e.name = $sformatf("vec%0d", i);
      e.e1 = vecs[i].e1; e.e2 = vecs[i].e2; e.e3 = vecs[i].e3;
      sb.push_back(e);
      edge_and_pop();
    end

    // Combinational read: address change visible without an edge.
    bus.addrRead1 = 3'd6; bus.addrRead2 = 3'd5; bus.addrRead3 = 3'd1;
    #1;
    check("comb.d1", bus.dataOut1, 8'h66);
    check("comb.d2", bus.dataOut2, 8'h3C);
    check("comb.d3", bus.dataOut3, 8'h11);

    // Same-cycle read/write on reg 4: old before the edge, new after.
    model_cycle("r4_init", 1'b1, 3'd4, 8'h10, 3'd4, 3'd4, 3'd4);
    drive(1'b1, 3'd4, 8'h20, 3'd4, 3'd0, 3'd4);
    #1;
    check("rw_before.d1", bus.dataOut1, 8'h10);
    check("rw_before.d3", bus.dataOut3, 8'h10);
    model_cycle("rw_after", 1'b1, 3'd4, 8'h20, 3'd4, 3'd0, 3'd4);

    // Random run against the reference array.
    for (int c = 0; c < 250; c++)
      model_cycle($sformatf("rnd%0d", c), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
